// File: rtl/signal_event_monitor_if.sv
// Record drain port of the signal event monitor: head timestamp/value with valid/ready.
// The monitor drives the master side; a trace sink or harness takes the slave side.
interface signal_event_monitor_if #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned TS_W  = 16
);
    logic             valid;
    logic             ready;
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] val;

    modport master (output valid, output ts, output val, input ready);
    modport slave  (input valid, input ts, input val, output ready);
endinterface

// File: rtl/signal_event_monitor.sv
// Synthesizable $monitor/$strobe counterpart: logs timestamped samples of a signal bundle
// (on change or every PERIOD cycles) into a first-word-fall-through FIFO.
module signal_event_monitor #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned PERIOD = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_mode,
    input  logic                   i_clr,
    input  logic [WIDTH-1:0]       i_sig_in,
    signal_event_monitor_if.master o_trace,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    output logic [7:0]             o_drop_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned RW = TS_W + WIDTH;
    localparam logic [CW-1:0] ScntLast = CW'(PERIOD - 1);
    localparam logic [LW-1:0] LvlFull  = LW'(DEPTH);

    logic [TS_W-1:0]  r_ts;
    logic [WIDTH-1:0] r_prev;
    logic             r_armed;
    logic             r_mode;
    logic [CW-1:0]    r_scnt;

    logic [RW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;
    logic [TS_W-1:0]  r_hold_ts;
    logic [WIDTH-1:0] r_hold_val;

    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_mode_chg;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic [RW-1:0]    w_head;

    assign w_valid    = (r_level != '0);
    assign w_full     = (r_level == LvlFull);
    assign w_pop      = w_valid && o_trace.ready;
    assign w_mode_chg = i_en && r_armed && (i_mode != r_mode);
    assign w_head     = r_mem[r_rptr];

    always_comb begin
        w_push_req = 1'b0;
        if (i_en && !w_mode_chg && !i_clr) begin
            if (!i_mode) begin
                w_push_req = !r_armed || (i_sig_in != r_prev);
            end else begin
                w_push_req = !r_armed || (r_scnt == ScntLast);
            end
        end
    end

    // A pop on the same edge frees the slot a push into a full FIFO needs.
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ts    <= '0;
            r_prev  <= '0;
            r_armed <= 1'b0;
            r_mode  <= 1'b0;
            r_scnt  <= '0;
        end else begin
            r_ts   <= r_ts + 1'b1;
            r_mode <= i_mode;
            if (i_clr || !i_en || w_mode_chg) begin
                r_armed <= 1'b0;
                r_scnt  <= '0;
            end else if (!i_mode) begin
                r_prev  <= i_sig_in;
                r_armed <= 1'b1;
            end else if (w_push_req) begin
                r_scnt  <= '0;
                r_armed <= 1'b1;
            end else begin
                r_scnt <= r_scnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            r_mem[r_wptr] <= {r_ts, i_sig_in};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Last visible head, shown while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold_ts  <= '0;
            r_hold_val <= '0;
        end else if (w_valid) begin
            r_hold_ts  <= w_head[RW-1:WIDTH];
            r_hold_val <= w_head[WIDTH-1:0];
        end
    end

    assign o_trace.valid = w_valid;
    assign o_trace.ts    = w_valid ? w_head[RW-1:WIDTH] : r_hold_ts;
    assign o_trace.val   = w_valid ? w_head[WIDTH-1:0]  : r_hold_val;
    assign o_level       = r_level;
    assign o_overflow    = r_overflow;
    assign o_drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_signal_event_monitor.sv
// Bench for signal_event_monitor: directed scenarios plus randomized traffic against a
// queue-based record model; a 4-bit-timestamp twin exercises timestamp wrap.
module tb_signal_event_monitor;
    localparam int unsigned WIDTH  = 3;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned PERIOD = 4;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;

    typedef struct {
        int unsigned      ts;
        logic [WIDTH-1:0] val;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n, en, mode, clr, ready;
    logic [WIDTH-1:0] sig;
    logic [LW-1:0]    level, level4;
    logic             overflow, overflow4;
    logic [7:0]       drop_cnt, drop_cnt4;

    signal_event_monitor_if #(.WIDTH(WIDTH), .TS_W(TS_W)) trace ();
    signal_event_monitor_if #(.WIDTH(WIDTH), .TS_W(4))    trace4 ();
    assign trace.ready  = ready;
    assign trace4.ready = ready;

    signal_event_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W), .PERIOD(PERIOD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_clr(clr), .i_sig_in(sig),
        .o_trace(trace), .o_level(level), .o_overflow(overflow), .o_drop_cnt(drop_cnt)
    );

    signal_event_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(4), .PERIOD(PERIOD)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_clr(clr), .i_sig_in(sig),
        .o_trace(trace4), .o_level(level4), .o_overflow(overflow4), .o_drop_cnt(drop_cnt4)
    );

    always #5 clk = ~clk;

    // Reference model: a record queue plus the capture rules stated as plain conditions.
    rec_t             mq[$];
    rec_t             obs[$];
    rec_t             obs4[$];
    int unsigned      m_ts, m_strobe_ts, m_drops, m_hold_ts;
    bit               m_armed, m_ovf;
    logic [WIDTH-1:0] m_prev, m_hold_val;
    int               n_checks = 0;
    int               n_err = 0;

    task automatic model_step();
        bit   pop, want;
        rec_t r;
        if (!rst_n) begin
            mq.delete();
            m_ts = 0; m_strobe_ts = 0; m_drops = 0; m_hold_ts = 0; m_hold_val = '0;
            m_armed = 0; m_ovf = 0; m_prev = '0;
            return;
        end
        if (mq.size() != 0) begin
            m_hold_ts  = mq[0].ts;
            m_hold_val = mq[0].val;
        end
        pop  = ready && (mq.size() != 0);
        want = 0;
        if (clr) begin
            mq.delete();
            m_ovf = 0; m_drops = 0; m_armed = 0;
        end else if (!en) begin
            m_armed = 0;
        end else if (!mode) begin
            want    = !m_armed || (sig != m_prev);
            m_prev  = sig;
            m_armed = 1;
        end else begin
            want = !m_armed || (((m_ts - m_strobe_ts) & 32'hFFFF) == PERIOD);
            if (want) begin
                m_strobe_ts = m_ts;
                m_armed     = 1;
            end
        end
        if (!clr && pop) void'(mq.pop_front());
        if (want) begin
            if (mq.size() < DEPTH) begin
                r.ts = m_ts; r.val = sig;
                mq.push_back(r);
            end else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        m_ts = (m_ts + 1) & 32'hFFFF;
    endtask

    task automatic tick();
        rec_t r;
        if (rst_n && !clr && ready && trace.valid === 1'b1) begin
            r.ts = trace.ts; r.val = trace.val; obs.push_back(r);
        end
        if (rst_n && !clr && ready && trace4.valid === 1'b1) begin
            r.ts = trace4.ts; r.val = trace4.val; obs4.push_back(r);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        tick();
        rst_n = 1'b1;
        obs.delete();
        obs4.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; clr = 1'b0; sig = '0; ready = 1'b0;
        tick();
        tick();
        n_checks++; if (trace.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", trace.valid); end
        n_checks++; if (level !== 0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
        n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        n_checks++; if (drop_cnt !== 0) begin n_err++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
        n_checks++; if (trace.ts !== 0) begin n_err++; $display("FAIL rst_ts: got %0d want 0", trace.ts); end
        n_checks++; if (trace.val !== 0) begin n_err++; $display("FAIL rst_val: got %0d want 0", trace.val); end
        rst_n = 1'b1;
    endtask

    task automatic test_snapshot_change();
        int unsigned      exp_ts[3]  = '{2, 4, 5};
        logic [WIDTH-1:0] exp_val[3] = '{3'b000, 3'b001, 3'b000};
        do_reset();
        mode = 1'b0; ready = 1'b1; sig = '0;
        while (m_ts < 2) tick();
        en = 1'b1; tick();
        tick();
        sig = 3'b001; tick();
        sig = 3'b000; tick();
        repeat (3) tick();
        n_checks++; if (obs.size() != 3) begin n_err++; $display("FAIL snap_count: got %0d want 3", obs.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= obs.size() || obs[i].ts != exp_ts[i] || obs[i].val !== exp_val[i]) begin
                n_err++;
                $display("FAIL snap_rec%0d: got ts=%0d val=%0d want ts=%0d val=%0d", i,
                         (i < obs.size()) ? obs[i].ts : 0, (i < obs.size()) ? obs[i].val : 3'd0,
                         exp_ts[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_toggle_chain();
        int unsigned      exp_ts[5]  = '{0, 3, 4, 5, 6};
        logic [WIDTH-1:0] exp_val[5] = '{3'b000, 3'b111, 3'b110, 3'b101, 3'b100};
        logic a, b, c, a_n, b_n;
        do_reset();
        mode = 1'b0; ready = 1'b1; en = 1'b1;
        a = 0; b = 0; c = 0;
        for (int t = 0; t < 10; t++) begin
            a_n = (m_ts >= 3 && m_ts <= 6) ? ~a : a;
            b_n = (a_n && !a) ? ~b : b;
            if (b_n && !b) c = ~c;
            a = a_n; b = b_n;
            sig = {c, b, a};
            tick();
        end
        en = 1'b0; tick();
        n_checks++; if (obs.size() != 5) begin n_err++; $display("FAIL chain_count: got %0d want 5", obs.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= obs.size() || obs[i].ts != exp_ts[i] || obs[i].val !== exp_val[i]) begin
                n_err++;
                $display("FAIL chain_rec%0d: got ts=%0d val=%0d want ts=%0d val=%0d", i,
                         (i < obs.size()) ? obs[i].ts : 0, (i < obs.size()) ? obs[i].val : 3'd0,
                         exp_ts[i], exp_val[i]);
            end
        end
        n_checks++; if (drop_cnt !== 0) begin n_err++; $display("FAIL chain_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_strobe();
        int unsigned exp_ts[4] = '{10, 14, 18, 22};
        do_reset();
        mode = 1'b1; ready = 1'b1; sig = 3'b101;
        while (m_ts < 10) tick();
        en = 1'b1;
        while (m_ts < 25) tick();
        en = 1'b0;
        n_checks++; if (obs.size() != 4) begin n_err++; $display("FAIL strobe_count: got %0d want 4", obs.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= obs.size() || obs[i].ts != exp_ts[i] || obs[i].val !== 3'b101) begin
                n_err++;
                $display("FAIL strobe_rec%0d: got ts=%0d val=%0d want ts=%0d val=5", i,
                         (i < obs.size()) ? obs[i].ts : 0, (i < obs.size()) ? obs[i].val : 3'd0,
                         exp_ts[i]);
            end
        end
        mode = 1'b0; tick();
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] v;
        do_reset();
        mode = 1'b0; ready = 1'b0; en = 1'b1;
        for (int i = 0; i < 11; i++) begin sig = 3'(i); tick(); end
        en = 1'b0;
        n_checks++; if (level !== 8) begin n_err++; $display("FAIL ovf_level: got %0d want 8", level); end
        n_checks++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_checks++; if (drop_cnt !== 3) begin n_err++; $display("FAIL ovf_drop: got %0d want 3", drop_cnt); end
        ready = 1'b1;
        repeat (10) tick();
        n_checks++; if (obs.size() != 8) begin n_err++; $display("FAIL ovf_drain_count: got %0d want 8", obs.size()); end
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            n_checks++;
            if (i >= obs.size() || obs[i].ts != i || obs[i].val !== v) begin
                n_err++;
                $display("FAIL ovf_rec%0d: got ts=%0d val=%0d want ts=%0d val=%0d", i,
                         (i < obs.size()) ? obs[i].ts : 0, (i < obs.size()) ? obs[i].val : 3'd0, i, v);
            end
        end
        n_checks++; if (overflow !== 1'b1 || drop_cnt !== 3) begin
            n_err++; $display("FAIL ovf_sticky: got ovf=%b drop=%0d want ovf=1 drop=3", overflow, drop_cnt);
        end
        ready = 1'b0; en = 1'b1;
        for (int i = 1; i <= 3; i++) begin sig = 3'(i); tick(); end
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        n_checks++; if (level !== 0) begin n_err++; $display("FAIL clr_level: got %0d want 0", level); end
        n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_overflow: got %b want 0", overflow); end
        n_checks++; if (drop_cnt !== 0) begin n_err++; $display("FAIL clr_drop: got %0d want 0", drop_cnt); end
        n_checks++; if (trace.valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", trace.valid); end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] v;
        do_reset();
        mode = 1'b0; ready = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin sig = 3'(i); tick(); end
        n_checks++; if (level !== 8) begin n_err++; $display("FAIL full_level: got %0d want 8", level); end
        sig = 3'd0; ready = 1'b1; tick();
        en = 1'b0;
        n_checks++; if (level !== 8) begin n_err++; $display("FAIL fullpp_level: got %0d want 8", level); end
        n_checks++; if (drop_cnt !== 0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL fullpp_drop: got drop=%0d ovf=%b want 0 0", drop_cnt, overflow);
        end
        n_checks++; if (trace.ts !== 1) begin n_err++; $display("FAIL fullpp_head: got ts=%0d want 1", trace.ts); end
        repeat (10) tick();
        n_checks++; if (obs.size() != 9) begin n_err++; $display("FAIL fullpp_count: got %0d want 9", obs.size()); end
        for (int i = 0; i < 9; i++) begin
            v = 3'(i);
            n_checks++;
            if (i >= obs.size() || obs[i].ts != i || obs[i].val !== v) begin
                n_err++;
                $display("FAIL fullpp_rec%0d: got ts=%0d val=%0d want ts=%0d val=%0d", i,
                         (i < obs.size()) ? obs[i].ts : 0, (i < obs.size()) ? obs[i].val : 3'd0, i, v);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 1'b0; ready = 1'b0; en = 1'b1;
        for (int i = 1; i <= 5; i++) begin sig = 3'(i); tick(); end
        n_checks++; if (level !== 5) begin n_err++; $display("FAIL mid_fill: got %0d want 5", level); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_checks++; if (level !== 0) begin n_err++; $display("FAIL mid_level: got %0d want 0", level); end
        n_checks++; if (trace.valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", trace.valid); end
        sig = 3'd6; tick();
        n_checks++; if (trace.valid !== 1'b1 || trace.ts !== 0 || trace.val !== 3'd6) begin
            n_err++;
            $display("FAIL mid_first: got v=%b ts=%0d val=%0d want v=1 ts=0 val=6",
                     trace.valid, trace.ts, trace.val);
        end
        en = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        mode = 1'b0; ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 20; i++) begin sig = 3'(i); tick(); end
        en = 1'b0; tick(); tick();
        n_checks++; if (obs4.size() != 20) begin n_err++; $display("FAIL wrap_count: got %0d want 20", obs4.size()); end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (i >= obs4.size() || obs4[i].ts != (i % 16)) begin
                n_err++;
                $display("FAIL wrap_rec%0d: got ts=%0d want ts=%0d", i,
                         (i < obs4.size()) ? obs4[i].ts : 99, i % 16);
            end
        end
        n_checks++; if (obs.size() != 20 || obs[16].ts != 16) begin
            n_err++; $display("FAIL wrap_wide: got n=%0d want n=20 ts16=16", obs.size());
        end
    endtask

    task automatic test_random();
        int unsigned      e_ts;
        logic [WIDTH-1:0] e_val;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            en = ($urandom_range(0, 9) != 0);
            if (!en && $urandom_range(0, 1) == 1) mode = ~mode;
            clr   = ($urandom_range(0, 59) == 0);
            ready = ((cyc % 100) < 30) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) sig = 3'($urandom);
            tick();
            e_ts  = (mq.size() != 0) ? mq[0].ts  : m_hold_ts;
            e_val = (mq.size() != 0) ? mq[0].val : m_hold_val;
            n_checks++;
            if (trace.valid !== (mq.size() != 0) || level !== mq.size()) begin
                n_err++;
                $display("FAIL rnd_level c%0d: got v=%b lvl=%0d want lvl=%0d", cyc, trace.valid,
                         level, mq.size());
            end
            n_checks++;
            if (trace.ts !== 16'(e_ts) || trace.val !== e_val) begin
                n_err++;
                $display("FAIL rnd_head c%0d: got ts=%0d val=%0d want ts=%0d val=%0d", cyc,
                         trace.ts, trace.val, e_ts, e_val);
            end
            n_checks++;
            if (overflow !== m_ovf || drop_cnt !== 8'(m_drops)) begin
                n_err++;
                $display("FAIL rnd_drop c%0d: got ovf=%b drop=%0d want ovf=%b drop=%0d", cyc,
                         overflow, drop_cnt, m_ovf, m_drops);
            end
            n_checks++;
            if (trace4.ts !== 4'(e_ts) || level4 !== mq.size() || overflow4 !== m_ovf ||
                drop_cnt4 !== 8'(m_drops)) begin
                n_err++;
                $display("FAIL rnd_ts4 c%0d: got ts=%0d lvl=%0d want ts=%0d lvl=%0d", cyc,
                         trace4.ts, level4, e_ts % 16, mq.size());
            end
        end
        clr = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_snapshot_change();
        test_toggle_chain();
        test_strobe();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
